// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundles every signal exchanged between the multicycle controller and the datapath.
//   master : the controller. It receives opcode/funct/zero/mem_ready and drives
//            all selects, enables, ALU control, the debug state and the retired count.
//   slave  : the datapath/memory side. It has the opposite directions.
interface multicycle_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;
    logic                 IorD;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ALUControl;
    logic [1:0]           PCSrc;
    logic                 PCEn;
    logic                 illegal_op;
    logic [3:0]           state;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op,
               state, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op,
               state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Sequencing FSM for the multicycle MIPS datapath (shared ALU, single memory).
// Walks each instruction through fetch/decode/execute/memory/writeback, emits
// all datapath controls, stalls on mem_ready and counts retired instructions.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (state -> FETCH, retired -> 0)
//   bus   : multicycle_ctrl_if.master, all controller inputs and outputs
module multicycle_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_if.master    bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] ADDIEX   = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_write, branch, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       retire;

    always_comb begin
        state_d     = FETCH;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                // IR load and PC+4 happen only on the cycle memory delivers the word
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                state_d   = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iord    = 1'b1;
                state_d = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                // strobe held for the whole access so a slow memory sees it until ready
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                case (bus.funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Every retiring state returns to FETCH unconditionally except MEMWRITE,
    // which only leaves once the store is accepted.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: retire = 1'b1;
            MEMWRITE:                           retire = bus.mem_ready;
            default:                            retire = 1'b0;
        endcase
        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign bus.IorD       = iord;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.PCSrc      = pc_src;
    assign bus.PCEn       = pc_write | (branch & bus.zero);
    assign bus.illegal_op = illegal;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Randomized instruction stream against a path-level reference: each
// instruction's expected state trace is built from its class and the number
// of memory stall cycles; per-instruction control pulse counts and the
// retired count (4-bit, so it wraps) are predicted arithmetically.
module tb_multicycle_ctrl;
    localparam int CW = 4;

    // instruction classes
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [CW-1:0] exp_ret;

    multicycle_ctrl_if #(.CNT_WIDTH(CW)) bus ();
    multicycle_ctrl #(.CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] op_of(input int k, input int sel);
        logic [5:0] ill [4];
        ill[0] = 6'b111111; ill[1] = 6'b000001; ill[2] = 6'b001100; ill[3] = 6'b110000;
        case (k)
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_R:     return 6'b000000;
            K_BEQ:   return 6'b000100;
            K_ADDI:  return 6'b001000;
            K_J:     return 6'b000010;
            default: return ill[sel % 4];
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Run one instruction: fs = FETCH stall cycles, ms = MEMREAD/MEMWRITE stall cycles.
    task automatic run_instr(input int k, input logic [5:0] fn, input logic z,
                             input int fs, input int ms, input int sel);
        logic [3:0] q_st[$];
        bit         q_mr[$];
        int n_rw = 0, n_pcen = 0, n_mw = 0, n_iord = 0, n_ir = 0, n_ill = 0;
        logic [5:0] op;
        op = op_of(k, sel);
        for (int i = 0; i < fs; i++) begin q_st.push_back(4'd0); q_mr.push_back(1'b0); end
        q_st.push_back(4'd0); q_mr.push_back(1'b1);
        q_st.push_back(4'd1); q_mr.push_back(1'($urandom_range(0, 1)));
        case (k)
            K_LW: begin
                q_st.push_back(4'd2); q_mr.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < ms; i++) begin q_st.push_back(4'd3); q_mr.push_back(1'b0); end
                q_st.push_back(4'd3); q_mr.push_back(1'b1);
                q_st.push_back(4'd4); q_mr.push_back(1'($urandom_range(0, 1)));
            end
            K_SW: begin
                q_st.push_back(4'd2); q_mr.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < ms; i++) begin q_st.push_back(4'd5); q_mr.push_back(1'b0); end
                q_st.push_back(4'd5); q_mr.push_back(1'b1);
            end
            K_R: begin
                q_st.push_back(4'd6); q_mr.push_back(1'($urandom_range(0, 1)));
                q_st.push_back(4'd7); q_mr.push_back(1'($urandom_range(0, 1)));
            end
            K_BEQ: begin q_st.push_back(4'd8); q_mr.push_back(1'($urandom_range(0, 1))); end
            K_ADDI: begin
                q_st.push_back(4'd9);  q_mr.push_back(1'($urandom_range(0, 1)));
                q_st.push_back(4'd10); q_mr.push_back(1'($urandom_range(0, 1)));
            end
            K_J: begin q_st.push_back(4'd11); q_mr.push_back(1'($urandom_range(0, 1))); end
            default: ;
        endcase

        for (int c = 0; c < q_st.size(); c++) begin
            @(negedge clk);
            bus.opcode    = op;
            bus.funct     = fn;
            bus.zero      = z;
            bus.mem_ready = q_mr[c];
            #1;
            if (c == 0) check_val("retired", 32'(bus.retired), 32'(exp_ret));
            check_val("state", 32'(bus.state), 32'(q_st[c]));
            if (q_st[c] == 4'd6) check_val("alu_exec", 32'(bus.ALUControl), 32'(alu_of(fn)));
            if (q_st[c] == 4'd8) begin
                check_val("alu_beq", 32'(bus.ALUControl), 32'd6);
                check_val("pcsrc_beq", 32'(bus.PCSrc), 32'd1);
            end
            if (q_st[c] == 4'd11) check_val("pcsrc_j", 32'(bus.PCSrc), 32'd2);
            if (bus.RegWrite) begin
                check_val("memtoreg", 32'(bus.MemtoReg), 32'(k == K_LW));
                check_val("regdst", 32'(bus.RegDst), 32'(k == K_R));
            end
            n_rw   += int'(bus.RegWrite);
            n_pcen += int'(bus.PCEn);
            n_mw   += int'(bus.MemWrite);
            n_iord += int'(bus.IorD);
            n_ir   += int'(bus.IRWrite);
            n_ill  += int'(bus.illegal_op);
        end
        check_val("regwrite_cnt", 32'(n_rw), 32'(k == K_LW || k == K_R || k == K_ADDI));
        check_val("pcen_cnt", 32'(n_pcen), 32'(1 + int'(k == K_J) + int'(k == K_BEQ && z)));
        check_val("memwrite_cnt", 32'(n_mw), (k == K_SW) ? 32'(ms + 1) : 32'd0);
        check_val("iord_cnt", 32'(n_iord), (k == K_SW || k == K_LW) ? 32'(ms + 1) : 32'd0);
        check_val("irwrite_cnt", 32'(n_ir), 32'd1);
        check_val("illegal_cnt", 32'(n_ill), 32'(k == K_ILL));
        if (k != K_ILL) exp_ret = exp_ret + 1'b1;
        $display("instr kind=%0d op=%06b fn=%06b z=%0d fstall=%0d mstall=%0d cycles=%0d exp_retired=%0d",
                 k, op, fn, z, fs, ms, q_st.size(), exp_ret);
    endtask

    task automatic random_instrs(input int n);
        logic [5:0] fns [5];
        fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
        fns[3] = 6'b100101; fns[4] = 6'b101010;
        for (int i = 0; i < n; i++) begin
            int k;
            logic [5:0] fn;
            k  = $urandom_range(0, 6);
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(k, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = 6'b0;
        bus.funct     = 6'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        exp_ret       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", 32'(bus.state), 32'd0);
        check_val("rst_retired", 32'(bus.retired), 32'd0);
        check_val("rst_pcen", 32'(bus.PCEn), 32'd0);
        check_val("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
        reset = 1'b0;

        run_instr(K_R, 6'b100010, 1'b0, 0, 0, 0);    // sub: 0,1,6,7
        run_instr(K_LW, 6'b0, 1'b0, 0, 3, 0);        // lw with 3 MEMREAD stalls
        run_instr(K_BEQ, 6'b0, 1'b1, 0, 0, 0);       // taken
        run_instr(K_BEQ, 6'b0, 1'b0, 0, 0, 0);       // not taken
        run_instr(K_ILL, 6'b0, 1'b0, 0, 0, 0);       // opcode 111111
        run_instr(K_SW, 6'b0, 1'b0, 1, 2, 0);
        random_instrs(20);

        // reset while a store sits in MEMWRITE
        @(negedge clk); bus.opcode = 6'b101011; bus.mem_ready = 1'b1;   // FETCH
        @(negedge clk);                                                 // DECODE
        @(negedge clk);                                                 // MEMADR
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        check_val("pre_rst_state", 32'(bus.state), 32'd5);
        check_val("pre_rst_memwrite", 32'(bus.MemWrite), 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        check_val("midrst_state", 32'(bus.state), 32'd0);
        check_val("midrst_memwrite", 32'(bus.MemWrite), 32'd0);
        check_val("midrst_retired", 32'(bus.retired), 32'd0);
        reset   = 1'b0;
        exp_ret = '0;
        $display("mid-instruction reset in MEMWRITE");

        random_instrs(60);
        @(negedge clk); #1;
        check_val("final_retired", 32'(bus.retired), 32'(exp_ret));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
